// File: rtl/fifo_block_sequencer.sv
// fifo_block_sequencer: gathers BLOCK_WORDS words from an RX FIFO into one block,
// hands it to an engine, then streams the engine's result block out to a TX FIFO.
module fifo_block_sequencer #(
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned BLOCK_WORDS = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              rx_empty,
  input  logic [DATA_SIZE-1:0]              rx_data,
  output logic                              rx_rd,
  input  logic                              tx_full,
  output logic                              tx_wr,
  output logic [DATA_SIZE-1:0]              tx_data,
  output logic [DATA_SIZE*BLOCK_WORDS-1:0]  blk_out,
  output logic                              blk_valid,
  input  logic                              blk_ready,
  input  logic [DATA_SIZE*BLOCK_WORDS-1:0]  res_in,
  input  logic                              res_valid,
  output logic                              res_ready,
  output logic                              busy,
  output logic [15:0]                       blk_count
);

  localparam int unsigned BW = DATA_SIZE * BLOCK_WORDS;
  localparam int unsigned IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT_RES, DRAIN} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic [BW-1:0] result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_rd      = 1'b0;
    tx_wr      = 1'b0;
    blk_valid  = 1'b0;
    res_ready  = 1'b0;
    case (state)
      IDLE:     if (enable) state_next = COLLECT;
      COLLECT: begin
        rx_rd = ~rx_empty;
        if (rx_rd && idx == LAST) state_next = ISSUE;
      end
      ISSUE: begin
        blk_valid = 1'b1;
        if (blk_ready) state_next = WAIT_RES;
      end
      WAIT_RES: begin
        res_ready = 1'b1;
        if (res_valid) state_next = DRAIN;
      end
      DRAIN: begin
        tx_wr = ~tx_full;
        if (tx_wr && idx == LAST) state_next = enable ? COLLECT : IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Word index 0 occupies the most significant slot of both blk_out and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      blk_out   <= '0;
      result    <= '0;
      blk_count <= '0;
    end else begin
      case (state)
        IDLE: idx <= '0;
        COLLECT: if (rx_rd) begin
          for (int unsigned i = 0; i < BLOCK_WORDS; i++)
            if (idx == IW'(i))
              blk_out[(BLOCK_WORDS-1-i)*DATA_SIZE +: DATA_SIZE] <= rx_data;
          idx <= (idx == LAST) ? '0 : idx + IW'(1);
        end
        WAIT_RES: if (res_valid) begin
          result <= res_in;
          idx    <= '0;
        end
        DRAIN: if (tx_wr) begin
          idx <= (idx == LAST) ? '0 : idx + IW'(1);
          if (idx == LAST) blk_count <= blk_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_data = '0;
    if (state == DRAIN)
      for (int unsigned i = 0; i < BLOCK_WORDS; i++)
        if (idx == IW'(i))
          tx_data = result[(BLOCK_WORDS-1-i)*DATA_SIZE +: DATA_SIZE];
  end

  assign busy = (state != IDLE);

endmodule
